// File: rtl/simon_core.sv
// Memory game controller: plays back a growing sequence from an external ROM,
// then checks the player's button presses against it, one round at a time.
module simon_core #(
  parameter  int N         = 16,
  parameter  int K         = 4,
  parameter  int ON_TICKS  = 2,
  parameter  int OFF_TICKS = 1,
  parameter  int TIMEOUT   = 0,
  parameter  int STRICT    = 0,
  localparam int VW        = ($clog2(K) > 1) ? $clog2(K) : 1,
  localparam int AW        = $clog2(N)
) (
  input  logic          clk_tick,
  input  logic          reset,
  input  logic          start_play,
  input  logic [VW-1:0] seq_val,
  output logic [AW-1:0] rd_addr,
  input  logic          btn_valid,
  input  logic [VW-1:0] btn_val,
  output logic [K-1:0]  led,
  output logic          error_led,
  output logic          win_led,
  output logic [AW:0]   score,
  output logic          busy
);

  localparam int TMAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int TW   = ($clog2(TMAX) > 0) ? $clog2(TMAX) : 1;
  localparam int TOW  = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;

  localparam logic [TW-1:0]  ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0]  OFF_LAST = TW'(OFF_TICKS - 1);
  localparam logic [TW-1:0]  ONE_T    = TW'(1);
  localparam logic [TOW-1:0] TO_LAST  = TOW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam logic [TOW-1:0] ONE_O    = TOW'(1);
  localparam logic [AW-1:0]  ONE_A    = AW'(1);
  localparam logic [AW:0]    ONE_R    = (AW + 1)'(1);
  localparam logic [AW:0]    N_W      = (AW + 1)'(N);
  localparam logic [VW:0]    K_W      = (VW + 1)'(K);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHOW_ON  = 3'd1,
    S_SHOW_OFF = 3'd2,
    S_WAIT     = 3'd3,
    S_CHECK    = 3'd4,
    S_ERROR    = 3'd5,
    S_WIN      = 3'd6
  } state_t;

  // Out-of-range indices shift the single one past the top bit, giving a dark display.
  function automatic logic [K-1:0] onehot(input logic [VW-1:0] v);
    onehot = {{(K - 1){1'b0}}, 1'b1} << v;
  endfunction

  state_t        state_r, state_nxt;
  logic [AW:0]   round_r, round_nxt;
  logic [AW-1:0] play_idx_r, play_idx_nxt;
  logic [AW-1:0] input_idx_r, input_idx_nxt;
  logic [TW-1:0] tick_r, tick_nxt;
  logic [TOW-1:0] tmo_r, tmo_nxt;
  logic [VW-1:0] latched_btn_r, latched_nxt;
  logic [AW-1:0] rd_addr_r, rd_addr_nxt;
  logic [AW:0]   score_r, score_nxt;
  logic          go_s;
  logic          match_s;
  logic [K-1:0]  led_s;

  assign go_s = (((state_r == S_IDLE) || (state_r == S_WIN)) && start_play) ||
                ((state_r == S_ERROR) && (start_play || btn_valid));

  assign match_s = ({1'b0, latched_btn_r} < K_W) && (latched_btn_r == seq_val);

  // Next-state and datapath update for the game sequencer
  always_comb begin
    state_nxt     = state_r;
    round_nxt     = round_r;
    play_idx_nxt  = play_idx_r;
    input_idx_nxt = input_idx_r;
    tick_nxt      = tick_r;
    tmo_nxt       = tmo_r;
    latched_nxt   = latched_btn_r;
    rd_addr_nxt   = rd_addr_r;
    score_nxt     = score_r;
    case (state_r)
      S_IDLE, S_ERROR, S_WIN: begin
        if (go_s) begin
          state_nxt     = S_SHOW_ON;
          round_nxt     = ONE_R;
          play_idx_nxt  = '0;
          input_idx_nxt = '0;
          rd_addr_nxt   = '0;
          score_nxt     = '0;
          tick_nxt      = '0;
        end else begin
          state_nxt = state_r;
        end
      end
      S_SHOW_ON: begin
        if ((STRICT != 0) && btn_valid) begin
          state_nxt = S_ERROR;
        end else if (tick_r == ON_LAST) begin
          state_nxt = S_SHOW_OFF;
          tick_nxt  = '0;
        end else begin
          tick_nxt = tick_r + ONE_T;
        end
      end
      S_SHOW_OFF: begin
        if ((STRICT != 0) && btn_valid) begin
          state_nxt = S_ERROR;
        end else if (tick_r != OFF_LAST) begin
          tick_nxt = tick_r + ONE_T;
        end else if (({1'b0, play_idx_r} + ONE_R) < round_r) begin
          state_nxt    = S_SHOW_ON;
          tick_nxt     = '0;
          play_idx_nxt = play_idx_r + ONE_A;
          rd_addr_nxt  = rd_addr_r + ONE_A;
        end else begin
          state_nxt     = S_WAIT;
          tick_nxt      = '0;
          input_idx_nxt = '0;
          rd_addr_nxt   = '0;
          tmo_nxt       = '0;
        end
      end
      S_WAIT: begin
        // A press on the final allowed cycle takes priority over the timeout.
        if (btn_valid) begin
          latched_nxt = btn_val;
          state_nxt   = S_CHECK;
        end else if ((TIMEOUT > 0) && (tmo_r == TO_LAST)) begin
          state_nxt = S_ERROR;
        end else if (TIMEOUT > 0) begin
          tmo_nxt = tmo_r + ONE_O;
        end else begin
          tmo_nxt = tmo_r;
        end
      end
      S_CHECK: begin
        if (!match_s) begin
          state_nxt = S_ERROR;
        end else if (({1'b0, input_idx_r} + ONE_R) < round_r) begin
          state_nxt     = S_WAIT;
          input_idx_nxt = input_idx_r + ONE_A;
          rd_addr_nxt   = rd_addr_r + ONE_A;
          tmo_nxt       = '0;
        end else if (round_r == N_W) begin
          score_nxt = score_r + ONE_R;
          state_nxt = S_WIN;
        end else begin
          score_nxt    = score_r + ONE_R;
          state_nxt    = S_SHOW_ON;
          round_nxt    = round_r + ONE_R;
          play_idx_nxt = '0;
          rd_addr_nxt  = '0;
          tick_nxt     = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk_tick) begin
    if (reset) begin
      state_r       <= S_IDLE;
      round_r       <= '0;
      play_idx_r    <= '0;
      input_idx_r   <= '0;
      tick_r        <= '0;
      tmo_r         <= '0;
      latched_btn_r <= '0;
      rd_addr_r     <= '0;
      score_r       <= '0;
    end else begin
      state_r       <= state_nxt;
      round_r       <= round_nxt;
      play_idx_r    <= play_idx_nxt;
      input_idx_r   <= input_idx_nxt;
      tick_r        <= tick_nxt;
      tmo_r         <= tmo_nxt;
      latched_btn_r <= latched_nxt;
      rd_addr_r     <= rd_addr_nxt;
      score_r       <= score_nxt;
    end
  end

  // Display decode from state, current ROM entry and latched press
  always_comb begin
    led_s = '0;
    case (state_r)
      S_SHOW_ON: led_s = onehot(seq_val);
      S_CHECK:   led_s = onehot(latched_btn_r);
      S_WIN:     led_s = '1;
      default:   led_s = '0;
    endcase
  end

  assign led       = led_s;
  assign rd_addr   = rd_addr_r;
  assign score     = score_r;
  assign error_led = (state_r == S_ERROR);
  assign win_led   = (state_r == S_WIN);
  assign busy      = (state_r == S_SHOW_ON) || (state_r == S_SHOW_OFF) ||
                     (state_r == S_CHECK);

endmodule
